// File: rtl/adc_sample_scheduler_pkg.sv
// Shared types and MCP3008 command helpers for the ADC sample scheduler.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_PUBLISH
    } state_t;

    localparam logic [1:0] START_SINGLE   = 2'b11;
    localparam int         DONT_CARE_BITS = 12;
    localparam int         CMD_WIDTH      = 2 + 3 + DONT_CARE_BITS;

    // Single-ended start + channel select, followed by the clock-out window for the result.
    function automatic logic [CMD_WIDTH-1:0] build_cmd(input logic [2:0] ch);
        return {START_SINGLE, ch, {DONT_CARE_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// Handshake between the scheduler and the MCP3008 SPI controller.
interface adc_sample_scheduler_if #(
    parameter int ADC_DATA_WIDTH = 17
);
    logic                      spi_trigger_out;
    logic [ADC_DATA_WIDTH-1:0] spi_data_out;
    logic                      spi_data_valid_in;
    logic [ADC_DATA_WIDTH-1:0] spi_data_in;

    modport master (
        output spi_trigger_out,
        output spi_data_out,
        input  spi_data_valid_in,
        input  spi_data_in
    );

    modport slave (
        input  spi_trigger_out,
        input  spi_data_out,
        output spi_data_valid_in,
        output spi_data_in
    );
endinterface

// File: rtl/adc_sample_scheduler_period_timer.sv
// Free-running frame period counter; held at zero while disabled so the
// first enabled cycle always produces a tick.
module period_timer #(
    parameter int PERIOD = 100_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic enable_in,
    output logic tick_out
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] r_count;

    always_ff @(posedge clk_in) begin
        if (rst_in || !enable_in)
            r_count <= '0;
        else if (r_count == CW'(PERIOD - 1))
            r_count <= '0;
        else
            r_count <= r_count + CW'(1);
    end

    assign tick_out = (r_count == '0) && enable_in;
endmodule

// File: rtl/adc_sample_scheduler.sv
// Walks the MCP3008 through one conversion per channel each sample period and
// publishes the whole set as a single coherent frame.
module adc_sample_scheduler
    import adc_pkg::*;
#(
    parameter int NUM_CHANNELS         = 2,
    parameter int CHANNEL_SELECT_WIDTH = 3,
    parameter int ADC_DATA_WIDTH       = 17,
    parameter int SAMPLE_WIDTH         = 10,
    parameter int DATA_START_INDEX     = 1,
    parameter int SAMPLE_PERIOD        = 100_000,
    parameter int SPI_TIMEOUT          = 4096
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic                                      enable_in,
    adc_sample_scheduler_if.master                    spi,
    output logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] frame_data_out,
    output logic                                      frame_valid_out,
    output logic                                      busy_out,
    output logic                                      overrun_out,
    output logic                                      timeout_out
);
    localparam int TW = (SPI_TIMEOUT > 1) ? $clog2(SPI_TIMEOUT) : 1;

    state_t                                    r_state;
    state_t                                    w_next_state;
    logic [CHANNEL_SELECT_WIDTH-1:0]           r_ch;
    logic [CHANNEL_SELECT_WIDTH-1:0]           w_ch_next;
    logic [TW-1:0]                             r_tcnt;
    logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] r_staging;
    logic [NUM_CHANNELS-1:0][SAMPLE_WIDTH-1:0] r_frame;
    logic [ADC_DATA_WIDTH-1:0]                 r_cmd;
    logic                                      r_trigger;
    logic                                      r_fvalid;
    logic                                      r_overrun;
    logic                                      r_timeout;
    logic                                      w_tick;
    logic                                      w_last;
    logic                                      w_to_hit;
    logic [SAMPLE_WIDTH-1:0]                   w_sample;
    logic                                      w_unused_bits;

    period_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .enable_in(enable_in),
        .tick_out (w_tick)
    );

    assign w_last        = (r_ch == CHANNEL_SELECT_WIDTH'(NUM_CHANNELS - 1));
    assign w_sample      = spi.spi_data_in[DATA_START_INDEX +: SAMPLE_WIDTH];
    assign w_unused_bits = ^spi.spi_data_in;

    always_comb begin
        w_next_state = r_state;
        w_ch_next    = r_ch;
        w_to_hit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_next_state = ST_ISSUE;
                    w_ch_next    = '0;
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (spi.spi_data_valid_in) begin
                    w_next_state = ST_STORE;
                end else if (r_tcnt == TW'(SPI_TIMEOUT - 1)) begin
                    // Partial frame is abandoned; staging is simply never published.
                    w_next_state = ST_IDLE;
                    w_ch_next    = '0;
                    w_to_hit     = 1'b1;
                end
            end
            ST_STORE: begin
                if (w_last) begin
                    w_next_state = ST_PUBLISH;
                end else begin
                    w_next_state = ST_ISSUE;
                    w_ch_next    = r_ch + CHANNEL_SELECT_WIDTH'(1);
                end
            end
            ST_PUBLISH: begin
                w_next_state = ST_IDLE;
                w_ch_next    = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_ch_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_tcnt    <= '0;
            r_staging <= '0;
            r_frame   <= '0;
            r_cmd     <= '0;
            r_trigger <= 1'b0;
            r_fvalid  <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_ch      <= w_ch_next;
            r_trigger <= (w_next_state == ST_ISSUE);
            r_overrun <= w_tick && (r_state != ST_IDLE);
            r_timeout <= w_to_hit;
            r_fvalid  <= (r_state == ST_PUBLISH);

            // Timeout count reads 0 during ISSUE, so it equals cycles since the trigger.
            if (w_next_state == ST_ISSUE) begin
                r_cmd  <= ADC_DATA_WIDTH'(build_cmd(3'(w_ch_next)));
                r_tcnt <= '0;
            end else if (r_state == ST_ISSUE || r_state == ST_WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end

            if (r_state == ST_WAIT && spi.spi_data_valid_in) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (r_ch == CHANNEL_SELECT_WIDTH'(i))
                        r_staging[i] <= w_sample;
                end
            end

            if (r_state == ST_PUBLISH)
                r_frame <= r_staging;
        end
    end

    assign spi.spi_trigger_out = r_trigger;
    assign spi.spi_data_out    = r_cmd;
    assign frame_data_out      = r_frame;
    assign frame_valid_out     = r_fvalid;
    assign overrun_out         = r_overrun;
    assign timeout_out         = r_timeout;
    assign busy_out            = (r_state != ST_IDLE);
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: an SPI responder with configurable latency
// plus event logs checked against frame/tick/latency expectations.
module tb_adc_sample_scheduler;
    localparam int N      = 2;
    localparam int AW     = 17;
    localparam int SW     = 10;
    localparam int PERIOD = 200;
    // Long enough that the 150-cycle overrun latency does not also time out.
    localparam int SPI_TO = 160;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [N-1:0][SW-1:0] frame_data;
    logic fv, busy, ovr, tout;

    adc_sample_scheduler_if #(.ADC_DATA_WIDTH(AW)) spi_if ();

    adc_sample_scheduler #(
        .NUM_CHANNELS(N), .CHANNEL_SELECT_WIDTH(3), .ADC_DATA_WIDTH(AW),
        .SAMPLE_WIDTH(SW), .DATA_START_INDEX(1), .SAMPLE_PERIOD(PERIOD),
        .SPI_TIMEOUT(SPI_TO)
    ) dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en), .spi(spi_if),
        .frame_data_out(frame_data), .frame_valid_out(fv), .busy_out(busy),
        .overrun_out(ovr), .timeout_out(tout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Event logs, stamped with the cycle in which the output was high.
    int              trig_c[$];
    logic [AW-1:0]   trig_cmd[$];
    int              fv_c[$];
    logic [N*SW-1:0] fv_d[$];
    int              ovr_c[$];
    int              to_c[$];
    logic [SW-1:0]   resp_smp[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (spi_if.spi_trigger_out) begin
                trig_c.push_back(cyc);
                trig_cmd.push_back(spi_if.spi_data_out);
            end
            if (fv) begin
                fv_c.push_back(cyc);
                fv_d.push_back(frame_data);
            end
            if (ovr)  ovr_c.push_back(cyc);
            if (tout) to_c.push_back(cyc);
        end
    end

    int            lat       = 20;
    int            drop_ch   = -1;
    bit            use_fixed = 1'b0;
    logic [SW-1:0] fixed_smp [N];
    int            stray_cnt = 0;

    // SPI controller model: answers each trigger 'lat' cycles later.
    initial begin : responder
        int            pend_at;
        int            stray_done;
        int            ch;
        logic [AW-1:0] pend_word;
        logic [SW-1:0] smp;
        pend_at = -1;
        stray_done = 0;
        pend_word = '0;
        spi_if.spi_data_valid_in = 1'b0;
        spi_if.spi_data_in = '0;
        forever begin
            @(negedge clk);
            spi_if.spi_data_valid_in = 1'b0;
            if (rst) begin
                pend_at = -1;
            end else begin
                if (spi_if.spi_trigger_out) begin
                    ch = int'(spi_if.spi_data_out[14:12]);
                    if (ch != drop_ch) begin
                        smp = (use_fixed && ch < N) ? fixed_smp[ch] : SW'($urandom);
                        pend_at = cyc + lat;
                        pend_word = {6'($urandom), smp, 1'($urandom)};
                        resp_smp.push_back(smp);
                    end
                end
                if (pend_at == cyc) begin
                    spi_if.spi_data_valid_in = 1'b1;
                    spi_if.spi_data_in = pend_word;
                    pend_at = -1;
                end else if (stray_cnt != stray_done) begin
                    spi_if.spi_data_valid_in = 1'b1;
                    spi_if.spi_data_in = AW'($urandom);
                    stray_done++;
                end
            end
        end
    end

    function automatic int tc(input int i);
        return (i < trig_c.size()) ? trig_c[i] : -1;
    endfunction
    function automatic logic [AW-1:0] tcmd(input int i);
        return (i < trig_cmd.size()) ? trig_cmd[i] : '0;
    endfunction
    function automatic int fvc(input int i);
        return (i < fv_c.size()) ? fv_c[i] : -1;
    endfunction
    function automatic logic [N*SW-1:0] fvd(input int i);
        return (i < fv_d.size()) ? fv_d[i] : '0;
    endfunction
    function automatic logic [SW-1:0] rs(input int i);
        return (i < resp_smp.size()) ? resp_smp[i] : '0;
    endfunction
    // Tick -> frame_valid: per channel the SPI wait (counted from the cycle
    // after the trigger, hence lat-1) plus 3 cycles, plus 2.
    function automatic int exp_lat(input int l);
        return N * (l - 1) + 3 * N + 2;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        drop_ch = -1;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        total++; if (spi_if.spi_trigger_out !== 1'b0) begin bad++; $display("FAIL reset_trigger: got %0b want 0", spi_if.spi_trigger_out); end
        total++; if (spi_if.spi_data_out !== '0) begin bad++; $display("FAIL reset_cmd: got %0h want 0", spi_if.spi_data_out); end
        total++; if (frame_data !== '0) begin bad++; $display("FAIL reset_frame: got %0h want 0", frame_data); end
        total++; if ({fv, busy, ovr, tout} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {fv, busy, ovr, tout}); end
        rst = 1'b0;
        step(3);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_disabled_busy: got %0b want 0", busy); end
    endtask

    task automatic test_normal_frame();
        int bt, bf, bo, bto, t0;
        logic [N*SW-1:0] exp;
        do_reset();
        bt = trig_c.size(); bf = fv_c.size(); bo = ovr_c.size(); bto = to_c.size();
        lat = 20; use_fixed = 1'b1; fixed_smp[0] = 10'h155; fixed_smp[1] = 10'h0AA;
        en = 1'b1; t0 = cyc;
        step(120);
        en = 1'b0;
        step(5);
        exp = {10'h0AA, 10'h155};
        total++; if (trig_c.size() - bt !== 2) begin bad++; $display("FAIL normal_trig_count: got %0d want 2", trig_c.size() - bt); end
        total++; if (tc(bt) !== t0 + 1) begin bad++; $display("FAIL normal_first_trig: got %0d want %0d", tc(bt), t0 + 1); end
        total++; if (tcmd(bt) !== 17'h18000) begin bad++; $display("FAIL normal_cmd0: got %0h want 18000", tcmd(bt)); end
        total++; if (tcmd(bt + 1) !== 17'h19000) begin bad++; $display("FAIL normal_cmd1: got %0h want 19000", tcmd(bt + 1)); end
        total++; if (fv_c.size() - bf !== 1) begin bad++; $display("FAIL normal_fv_count: got %0d want 1", fv_c.size() - bf); end
        total++; if (fvc(bf) !== t0 + exp_lat(lat)) begin bad++; $display("FAIL normal_latency: got %0d want %0d", fvc(bf), t0 + exp_lat(lat)); end
        total++; if (fvd(bf) !== exp) begin bad++; $display("FAIL normal_data: got %0h want %0h", fvd(bf), exp); end
        total++; if (frame_data !== exp) begin bad++; $display("FAIL normal_hold: got %0h want %0h", frame_data, exp); end
        total++; if ((ovr_c.size() - bo) + (to_c.size() - bto) !== 0) begin bad++; $display("FAIL normal_errs: got %0d want 0", (ovr_c.size() - bo) + (to_c.size() - bto)); end
        use_fixed = 1'b0;
    endtask

    task automatic test_periodicity();
        int bt, bf, bs, t0;
        int ticks[$];
        logic [N*SW-1:0] exp;
        do_reset();
        bt = trig_c.size(); bf = fv_c.size(); bs = resp_smp.size();
        lat = 20;
        en = 1'b1; t0 = cyc;
        step(1000);
        en = 1'b0;
        step(60);
        for (int c = 0; c < 1000; c++) if (c % PERIOD == 0) ticks.push_back(t0 + c);
        total++; if (fv_c.size() - bf !== ticks.size()) begin bad++; $display("FAIL period_frames: got %0d want %0d", fv_c.size() - bf, ticks.size()); end
        total++; if (trig_c.size() - bt !== N * ticks.size()) begin bad++; $display("FAIL period_trigs: got %0d want %0d", trig_c.size() - bt, N * ticks.size()); end
        for (int k = 0; k < ticks.size(); k++) begin
            exp = {rs(bs + N * k + 1), rs(bs + N * k)};
            total++; if (tc(bt + N * k) !== ticks[k] + 1) begin bad++; $display("FAIL period_trig%0d: got %0d want %0d", k, tc(bt + N * k), ticks[k] + 1); end
            total++; if (fvc(bf + k) !== ticks[k] + exp_lat(lat)) begin bad++; $display("FAIL period_fv%0d: got %0d want %0d", k, fvc(bf + k), ticks[k] + exp_lat(lat)); end
            total++; if (fvd(bf + k) !== exp) begin bad++; $display("FAIL period_data%0d: got %0h want %0h", k, fvd(bf + k), exp); end
        end
    endtask

    task automatic test_timeout();
        int bt, bf, bs, bto, t0, ch1_trig;
        logic [N*SW-1:0] first;
        do_reset();
        bt = trig_c.size(); bf = fv_c.size(); bs = resp_smp.size(); bto = to_c.size();
        lat = 20;
        en = 1'b1; t0 = cyc;
        step(60);
        drop_ch = 1;
        step(300);
        first = {rs(bs + 1), rs(bs)};
        total++; if (frame_data !== first) begin bad++; $display("FAIL timeout_frame_kept: got %0h want %0h", frame_data, first); end
        drop_ch = -1;
        step(100);
        en = 1'b0;
        step(60);
        // Second frame: ch1 trigger is one channel step after the tick's trigger.
        ch1_trig = t0 + PERIOD + 1 + (lat - 1) + 3;
        total++; if (to_c.size() - bto !== 1) begin bad++; $display("FAIL timeout_count: got %0d want 1", to_c.size() - bto); end
        total++; if ((bto < to_c.size() ? to_c[bto] : -1) !== ch1_trig + SPI_TO) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", (bto < to_c.size() ? to_c[bto] : -1), ch1_trig + SPI_TO); end
        total++; if (fv_c.size() - bf !== 2) begin bad++; $display("FAIL timeout_fv_count: got %0d want 2", fv_c.size() - bf); end
        total++; if (tc(bt + 4) !== t0 + 2 * PERIOD + 1) begin bad++; $display("FAIL timeout_restart_cyc: got %0d want %0d", tc(bt + 4), t0 + 2 * PERIOD + 1); end
        total++; if (tcmd(bt + 4) !== 17'h18000) begin bad++; $display("FAIL timeout_restart_ch0: got %0h want 18000", tcmd(bt + 4)); end
        total++; if (fvd(bf + 1) !== {rs(bs + 4), rs(bs + 3)}) begin bad++; $display("FAIL timeout_next_data: got %0h want %0h", fvd(bf + 1), {rs(bs + 4), rs(bs + 3)}); end
    endtask

    task automatic test_overrun();
        int bt, bf, bs, bo, bto, t0;
        do_reset();
        bt = trig_c.size(); bf = fv_c.size(); bs = resp_smp.size(); bo = ovr_c.size(); bto = to_c.size();
        lat = 150;
        en = 1'b1; t0 = cyc;
        step(410);
        en = 1'b0;
        step(400);
        total++; if (ovr_c.size() - bo !== 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", ovr_c.size() - bo); end
        total++; if ((bo < ovr_c.size() ? ovr_c[bo] : -1) !== t0 + PERIOD + 1) begin bad++; $display("FAIL overrun_cycle: got %0d want %0d", (bo < ovr_c.size() ? ovr_c[bo] : -1), t0 + PERIOD + 1); end
        total++; if (fvc(bf) !== t0 + exp_lat(lat)) begin bad++; $display("FAIL overrun_fv_cycle: got %0d want %0d", fvc(bf), t0 + exp_lat(lat)); end
        total++; if (fvd(bf) !== {rs(bs + 1), rs(bs)}) begin bad++; $display("FAIL overrun_data: got %0h want %0h", fvd(bf), {rs(bs + 1), rs(bs)}); end
        total++; if (tc(bt + 2) !== t0 + 2 * PERIOD + 1) begin bad++; $display("FAIL overrun_third_tick: got %0d want %0d", tc(bt + 2), t0 + 2 * PERIOD + 1); end
        total++; if (fv_c.size() - bf !== 2) begin bad++; $display("FAIL overrun_fv_count: got %0d want 2", fv_c.size() - bf); end
        total++; if (to_c.size() - bto !== 0) begin bad++; $display("FAIL overrun_no_timeout: got %0d want 0", to_c.size() - bto); end
        lat = 20;
    endtask

    task automatic test_disable_mid_frame();
        int bt, bf, t0;
        do_reset();
        bt = trig_c.size(); bf = fv_c.size();
        lat = 20;
        en = 1'b1; t0 = cyc;
        step(2);
        en = 1'b0;
        step(450);
        total++; if (trig_c.size() - bt !== N) begin bad++; $display("FAIL disable_trigs: got %0d want %0d", trig_c.size() - bt, N); end
        total++; if (fvc(bf) !== t0 + exp_lat(lat)) begin bad++; $display("FAIL disable_fv: got %0d want %0d", fvc(bf), t0 + exp_lat(lat)); end
        total++; if (fv_c.size() - bf !== 1) begin bad++; $display("FAIL disable_fv_count: got %0d want 1", fv_c.size() - bf); end
    endtask

    task automatic test_reset_mid_frame();
        int bf, bto;
        do_reset();
        lat = 20;
        en = 1'b1;
        step(10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %0b want 1", busy); end
        rst = 1'b1;
        step(1);
        total++; if ({spi_if.spi_trigger_out, fv, busy, ovr, tout} !== 5'b0) begin bad++; $display("FAIL rstmid_flags: got %b want 00000", {spi_if.spi_trigger_out, fv, busy, ovr, tout}); end
        total++; if (spi_if.spi_data_out !== '0) begin bad++; $display("FAIL rstmid_cmd: got %0h want 0", spi_if.spi_data_out); end
        total++; if (frame_data !== '0) begin bad++; $display("FAIL rstmid_frame: got %0h want 0", frame_data); end
        en = 1'b0;
        step(2);
        rst = 1'b0;
        bf = fv_c.size(); bto = to_c.size();
        step(250);
        total++; if ((fv_c.size() - bf) + (to_c.size() - bto) !== 0) begin bad++; $display("FAIL rstmid_no_pulses: got %0d want 0", (fv_c.size() - bf) + (to_c.size() - bto)); end
    endtask

    task automatic test_stray_valid();
        int bt, bf, bs, t1;
        logic [N*SW-1:0] exp;
        do_reset();
        lat = 20;
        bs = resp_smp.size();
        en = 1'b1;
        step(60);
        en = 1'b0;
        step(5);
        exp = {rs(bs + 1), rs(bs)};
        bt = trig_c.size(); bf = fv_c.size();
        stray_cnt++;
        step(6);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stray_busy: got %0b want 0", busy); end
        total++; if (frame_data !== exp) begin bad++; $display("FAIL stray_frame: got %0h want %0h", frame_data, exp); end
        total++; if ((trig_c.size() - bt) + (fv_c.size() - bf) !== 0) begin bad++; $display("FAIL stray_events: got %0d want 0", (trig_c.size() - bt) + (fv_c.size() - bf)); end
        bs = resp_smp.size();
        en = 1'b1; t1 = cyc;
        step(60);
        en = 1'b0;
        step(5);
        total++; if (fvc(bf) !== t1 + exp_lat(lat)) begin bad++; $display("FAIL stray_next_fv: got %0d want %0d", fvc(bf), t1 + exp_lat(lat)); end
        total++; if (fvd(bf) !== {rs(bs + 1), rs(bs)}) begin bad++; $display("FAIL stray_next_data: got %0h want %0h", fvd(bf), {rs(bs + 1), rs(bs)}); end
    endtask

    task automatic test_random_latency();
        int bf, bs, t0;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            lat = $urandom_range(20, 90);
            bf = fv_c.size(); bs = resp_smp.size();
            en = 1'b1; t0 = cyc;
            step(150);
            en = 1'b0;
            step(250);
            total++; if (fv_c.size() - bf !== 1) begin bad++; $display("FAIL rand%0d_count: got %0d want 1", it, fv_c.size() - bf); end
            total++; if (fvc(bf) !== t0 + exp_lat(lat)) begin bad++; $display("FAIL rand%0d_latency lat=%0d: got %0d want %0d", it, lat, fvc(bf), t0 + exp_lat(lat)); end
            total++; if (fvd(bf) !== {rs(bs + 1), rs(bs)}) begin bad++; $display("FAIL rand%0d_data: got %0h want %0h", it, fvd(bf), {rs(bs + 1), rs(bs)}); end
        end
        lat = 20;
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_periodicity();
        test_timeout();
        test_overrun();
        test_disable_mid_frame();
        test_reset_mid_frame();
        test_stray_valid();
        test_random_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
